// File: rtl/pingpong_merge_ctrl_if.sv
// Handshake and status bundle between the ping-pong sequencer and its surroundings
// (ADC valid stream, downstream reader and the two bank FIFOs).
//   master : the sequencer; consumes start/stop/sample_valid/rd_ready/FIFO flags and drives
//            the per-bank enables, bank selects, block_done, overrun, drop_count, state_out.
//   slave  : the environment side of the same signals.
interface pingpong_merge_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             stop;
  logic             sample_valid;
  logic             rd_ready;
  logic [1:0]       ff_full;
  logic [1:0]       ff_empty;
  logic [1:0]       wr_en;
  logic [1:0]       rd_en;
  logic             wr_bank;
  logic             rd_bank;
  logic             block_done;
  logic             overrun;
  logic [CNT_W-1:0] drop_count;
  logic [2:0]       state_out;

  modport master (
    input  start, stop, sample_valid, rd_ready, ff_full, ff_empty,
    output wr_en, rd_en, wr_bank, rd_bank, block_done, overrun, drop_count, state_out
  );

  modport slave (
    output start, stop, sample_valid, rd_ready, ff_full, ff_empty,
    input  wr_en, rd_en, wr_bank, rd_bank, block_done, overrun, drop_count, state_out
  );
endinterface

// File: rtl/pingpong_merge_ctrl.sv
// Sequencer for a two-bank ping-pong FIFO pair: fills one bank with BLOCK_LEN samples while
// the other drains, then swaps. Generates per-bank write/read enables from the FIFO flags,
// flags overruns and counts dropped samples. The sample data never passes through here.
// Ports:
//   clk_i  : system clock, rising edge
//   rst_i  : synchronous active-high reset
//   bus    : pingpong_merge_ctrl_if.master (control inputs, FIFO flags, enables and status)
module pingpong_merge_ctrl #(
  parameter int unsigned BLOCK_LEN = 16,
  parameter int unsigned CNT_W     = 16
) (
  input logic                    clk_i,
  input logic                    rst_i,
  pingpong_merge_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StFill     = 3'd1,
    StPingpong = 3'd2,
    StWaitRd   = 3'd3,
    StDrain    = 3'd4
  } state_e;

  localparam int unsigned IdxW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BLOCK_LEN - 1);

  state_e           state_q, state_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IdxW-1:0]  wr_cnt_q, wr_cnt_d;
  logic [IdxW-1:0]  rd_cnt_q, rd_cnt_d;
  logic             stop_pending_q, stop_pending_d;
  logic             block_done_q, block_done_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic writing, rd_active, wr_acc, rd_acc, wc, rc, drop, stop_now;

  always_comb begin
    writing   = (state_q == StFill) || (state_q == StPingpong);
    rd_active = (state_q == StPingpong) || (state_q == StWaitRd) || (state_q == StDrain);
    wr_acc    = bus.sample_valid && writing && !bus.ff_full[wr_bank_q];
    rd_acc    = rd_active && bus.rd_ready && !bus.ff_empty[rd_bank_q];
    wc        = wr_acc && (wr_cnt_q == LastIdx);
    rc        = rd_acc && (rd_cnt_q == LastIdx);
    // Every offered sample is lost in WAIT_RD; in FILL/PINGPONG only when the bank is full.
    drop      = bus.sample_valid && (writing || (state_q == StWaitRd)) && !wr_acc;
    // A stop arriving together with the block boundary takes effect at that boundary.
    stop_now  = stop_pending_q || bus.stop;
  end

  always_comb begin
    state_d        = state_q;
    wr_bank_d      = wr_bank_q;
    rd_bank_d      = rd_bank_q;
    wr_cnt_d       = wr_cnt_q;
    rd_cnt_d       = rd_cnt_q;
    stop_pending_d = stop_pending_q;
    block_done_d   = rc;
    overrun_d      = overrun_q;
    drop_cnt_d     = drop_cnt_q;

    if (wr_acc) wr_cnt_d = wc ? '0 : wr_cnt_q + 1'b1;
    if (rd_acc) rd_cnt_d = rc ? '0 : rd_cnt_q + 1'b1;

    if (drop) begin
      overrun_d = 1'b1;
      if (!(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + 1'b1;
    end

    if (bus.stop && (state_q != StIdle) && (state_q != StDrain)) stop_pending_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d        = StFill;
          wr_bank_d      = 1'b0;
          wr_cnt_d       = '0;
          rd_cnt_d       = '0;
          stop_pending_d = 1'b0;
          overrun_d      = 1'b0;
          drop_cnt_d     = '0;
        end
      end
      StFill: begin
        if (wc) begin
          rd_bank_d = wr_bank_q;
          wr_bank_d = ~wr_bank_q;
          state_d   = stop_now ? StDrain : StPingpong;
        end
      end
      StPingpong: begin
        if (wc && rc) begin
          rd_bank_d = wr_bank_q;
          wr_bank_d = ~wr_bank_q;
          state_d   = stop_now ? StDrain : StPingpong;
        end else if (wc) begin
          state_d = StWaitRd;
        end else if (rc) begin
          // Read bank emptied first; keep filling the current write bank on its own.
          state_d = StFill;
        end
      end
      StWaitRd: begin
        if (rc) begin
          rd_bank_d = wr_bank_q;
          wr_bank_d = ~wr_bank_q;
          state_d   = stop_now ? StDrain : StPingpong;
        end
      end
      StDrain: begin
        if (rc) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if ((state_d == StDrain) && (state_q != StDrain)) stop_pending_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b0;
      wr_cnt_q       <= '0;
      rd_cnt_q       <= '0;
      stop_pending_q <= 1'b0;
      block_done_q   <= 1'b0;
      overrun_q      <= 1'b0;
      drop_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      wr_bank_q      <= wr_bank_d;
      rd_bank_q      <= rd_bank_d;
      wr_cnt_q       <= wr_cnt_d;
      rd_cnt_q       <= rd_cnt_d;
      stop_pending_q <= stop_pending_d;
      block_done_q   <= block_done_d;
      overrun_q      <= overrun_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  assign bus.wr_en      = {wr_acc && wr_bank_q, wr_acc && !wr_bank_q};
  assign bus.rd_en      = {rd_acc && rd_bank_q, rd_acc && !rd_bank_q};
  assign bus.wr_bank    = wr_bank_q;
  assign bus.rd_bank    = rd_bank_q;
  assign bus.block_done = block_done_q;
  assign bus.overrun    = overrun_q;
  assign bus.drop_count = drop_cnt_q;
  assign bus.state_out  = state_q;

endmodule

// File: tb/tb_pingpong_merge_ctrl.sv
// Self-checking bench for pingpong_merge_ctrl with BLOCK_LEN=4, CNT_W=16 and depth-8 bank
// FIFO occupancy models. A block-level reference model predicts every output each cycle.
module tb_pingpong_merge_ctrl;
  localparam int unsigned L     = 4;
  localparam int unsigned CW    = 16;
  localparam int          DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pingpong_merge_ctrl_if #(.CNT_W(CW)) bus ();

  pingpong_merge_ctrl #(.BLOCK_LEN(L), .CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: controller viewed as "is a block being filled / read / held back".
  bit m_run, m_fill, m_read, m_held, m_stop, m_wb, m_rb, m_done, m_ovr;
  int m_wcnt, m_rcnt;
  int unsigned m_drops;
  int fcnt [2];

  bit c_rst, c_start, c_stop, c_sv, c_rr, e_wr, e_rd;
  logic [26:0] exp_vec;
  logic [26:0] obs_vec;
  assign obs_vec = {bus.state_out, bus.wr_en, bus.rd_en, bus.wr_bank, bus.rd_bank,
                    bus.block_done, bus.overrun, bus.drop_count};

  task automatic model_reset();
    m_run = 0; m_fill = 0; m_read = 0; m_held = 0; m_stop = 0;
    m_wb = 0; m_rb = 0; m_done = 0; m_ovr = 0;
    m_wcnt = 0; m_rcnt = 0; m_drops = 0;
    fcnt[0] = 0; fcnt[1] = 0;
  endtask

  function automatic logic [2:0] exp_state();
    if (!m_run) return 3'd0;
    if (m_held) return 3'd3;
    if (m_fill) return m_read ? 3'd2 : 3'd1;
    return 3'd4;
  endfunction

  // Apply one cycle of inputs, predict this cycle's outputs, then stop at the falling edge.
  task automatic drive(input bit r, st, sp, v, rr, input logic [1:0] sf, se);
    logic [1:0] full, empty, ew, er;
    c_rst = r; c_start = st; c_stop = sp; c_sv = v; c_rr = rr;
    for (int b = 0; b < 2; b++) begin
      full[b]  = (fcnt[b] >= DEPTH) | sf[b];
      empty[b] = (fcnt[b] == 0) | se[b];
    end
    rst = r;
    bus.start = st; bus.stop = sp; bus.sample_valid = v; bus.rd_ready = rr;
    bus.ff_full = full; bus.ff_empty = empty;
    e_wr = m_fill && v && !full[m_wb];
    e_rd = m_read && rr && !empty[m_rb];
    ew = 2'b00; er = 2'b00;
    if (e_wr) ew[m_wb] = 1'b1;
    if (e_rd) er[m_rb] = 1'b1;
    exp_vec = {exp_state(), ew, er, m_wb, m_rb, m_done, m_ovr, CW'(m_drops)};
    @(negedge clk);
  endtask

  // Move the model across the rising edge and wait until just after it.
  task automatic advance();
    bit wc, rc, drop, stop_now;
    if (c_rst) begin
      model_reset();
    end else begin
      wc   = e_wr && (m_wcnt == L - 1);
      rc   = e_rd && (m_rcnt == L - 1);
      drop = c_sv && m_run && (m_fill || m_held) && !e_wr;
      m_done = rc;
      if (e_wr) begin fcnt[m_wb]++; m_wcnt = wc ? 0 : m_wcnt + 1; end
      if (e_rd) begin fcnt[m_rb]--; m_rcnt = rc ? 0 : m_rcnt + 1; end
      if (drop) begin
        m_ovr = 1;
        if (m_drops < (1 << CW) - 1) m_drops++;
      end
      stop_now = m_stop || (c_stop && m_run && (m_fill || m_held));
      m_stop = stop_now;
      if (!m_run) begin
        if (c_start) begin
          m_run = 1; m_fill = 1; m_read = 0; m_held = 0; m_stop = 0;
          m_wb = 0; m_wcnt = 0; m_rcnt = 0; m_ovr = 0; m_drops = 0;
        end
      end else if (wc) begin
        if (m_read && !rc) begin
          m_held = 1; m_fill = 0;
        end else begin
          m_rb = m_wb; m_wb = !m_wb; m_read = 1;
          m_fill = !stop_now;
          if (stop_now) m_stop = 0;
        end
      end else if (rc) begin
        if (m_held) begin
          m_rb = m_wb; m_wb = !m_wb; m_held = 0;
          m_fill = !stop_now;
          if (stop_now) m_stop = 0;
        end else if (m_fill) begin
          m_read = 0;
        end else begin
          m_run = 0; m_read = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    drive(1, 0, 0, 0, 0, 2'b00, 2'b00); advance();
    drive(0, 1, 0, 0, 0, 2'b00, 2'b00); advance();
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 1, 1, 2'b00, 2'b00);
    tests++;
    if (obs_vec !== 27'd0) begin
      fails++; $display("FAIL reset_outputs obs=%h exp=0", obs_vec);
    end
    advance();
    // stop and samples in IDLE must do nothing
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 1, 1, 2'b00, 2'b00);
      tests++;
      if (obs_vec !== exp_vec || obs_vec !== 27'd0) begin
        fails++; $display("FAIL idle_quiet cyc%0d obs=%h exp=%h", i, obs_vec, exp_vec);
      end
      advance();
    end
  endtask

  task automatic test_fill();
    restart();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 0, 2'b00, 2'b00);
      tests++;
      if (obs_vec !== exp_vec || bus.wr_en !== 2'b01) begin
        fails++; $display("FAIL fill cyc%0d obs=%h exp=%h", i, obs_vec, exp_vec);
      end
      advance();
    end
    drive(0, 0, 0, 0, 0, 2'b00, 2'b00);
    tests++;
    if ({bus.state_out, bus.wr_bank, bus.rd_bank, bus.rd_en} !== {3'd2, 1'b1, 1'b0, 2'b00}) begin
      fails++; $display("FAIL fill_swap obs=%h exp=%h", obs_vec, exp_vec);
    end
    advance();
  endtask

  task automatic test_stream();
    int n_done = 0, n01 = 0, n10 = 0;
    restart();
    for (int i = 0; i < 40; i++) begin
      drive(0, 0, 0, 1, 1, 2'b00, 2'b00);
      tests++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL stream cyc%0d obs=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (bus.block_done === 1'b1) n_done++;
      if (bus.wr_en === 2'b01) n01++;
      if (bus.wr_en === 2'b10) n10++;
      advance();
    end
    drive(0, 0, 0, 0, 0, 2'b00, 2'b00);
    tests++;
    if (n_done != 8 || n01 != 20 || n10 != 20 || bus.drop_count !== 16'd0
        || bus.overrun !== 1'b0) begin
      fails++;
      $display("FAIL stream_totals done=%0d w01=%0d w10=%0d drops=%0d ovr=%b exp 8/20/20/0/0",
               n_done, n01, n10, bus.drop_count, bus.overrun);
    end
    advance();
  endtask

  task automatic test_overrun();
    restart();
    for (int i = 1; i <= 11; i++) begin
      drive(0, 0, 0, 1, 0, 2'b00, 2'b00);
      tests++;
      if (obs_vec !== exp_vec || (i == 9 && bus.state_out !== 3'd3)) begin
        fails++; $display("FAIL overrun_fill cyc%0d obs=%h exp=%h", i, obs_vec, exp_vec);
      end
      advance();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 2'b00, 2'b00);
      tests++;
      if (obs_vec !== exp_vec || bus.drop_count !== 16'd3 || bus.overrun !== 1'b1) begin
        fails++; $display("FAIL overrun_drain cyc%0d obs=%h exp=%h", i, obs_vec, exp_vec);
      end
      advance();
    end
    drive(0, 0, 0, 0, 0, 2'b00, 2'b00);
    tests++;
    if ({bus.state_out, bus.wr_bank, bus.rd_bank, bus.block_done}
        !== {3'd2, 1'b0, 1'b1, 1'b1}) begin
      fails++; $display("FAIL overrun_swap obs=%h exp=%h", obs_vec, exp_vec);
    end
    advance();
  endtask

  task automatic test_stop();
    restart();
    for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 1, 0, 2'b00, 2'b00); advance(); end
    for (int i = 0; i < 5; i++) begin
      // two write+read cycles, a stop pulse with an idle bus, then two more
      if (i == 2) drive(0, 0, 1, 0, 0, 2'b00, 2'b00);
      else drive(0, 0, 0, 1, 1, 2'b00, 2'b00);
      tests++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL stop_block cyc%0d obs=%h exp=%h", i, obs_vec, exp_vec);
      end
      advance();
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 1, 2'b00, 2'b00);
      tests++;
      if (obs_vec !== exp_vec || bus.state_out !== 3'd4 || bus.wr_en !== 2'b00) begin
        fails++; $display("FAIL stop_drain cyc%0d obs=%h exp=%h", i, obs_vec, exp_vec);
      end
      advance();
    end
    drive(0, 0, 0, 0, 0, 2'b00, 2'b00);
    tests++;
    if ({bus.state_out, bus.block_done, bus.drop_count} !== {3'd0, 1'b1, 16'd0}) begin
      fails++; $display("FAIL stop_idle obs=%h exp=%h", obs_vec, exp_vec);
    end
    advance();
  endtask

  task automatic test_back_to_back();
    restart();
    for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 1, 0, 2'b00, 2'b00); advance(); end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 1, 2'b00, 2'b00);
      tests++;
      if (obs_vec !== exp_vec || bus.block_done !== 1'b0) begin
        fails++; $display("FAIL b2b_block cyc%0d obs=%h exp=%h", i, obs_vec, exp_vec);
      end
      advance();
    end
    drive(0, 0, 0, 0, 0, 2'b00, 2'b00);
    tests++;
    if ({bus.state_out, bus.wr_bank, bus.rd_bank, bus.block_done}
        !== {3'd2, 1'b0, 1'b1, 1'b1}) begin
      fails++; $display("FAIL b2b_swap obs=%h exp=%h", obs_vec, exp_vec);
    end
    advance();
    drive(0, 0, 0, 0, 0, 2'b00, 2'b00);
    tests++;
    if (bus.block_done !== 1'b0 || obs_vec !== exp_vec) begin
      fails++; $display("FAIL b2b_done_once obs=%h exp=%h", obs_vec, exp_vec);
    end
    advance();
  endtask

  task automatic test_reset_mid();
    restart();
    for (int i = 0; i < 10; i++) begin drive(0, 0, 0, 1, 0, 2'b00, 2'b00); advance(); end
    for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 0, 1, 2'b00, 2'b00); advance(); end
    drive(1, 0, 0, 1, 1, 2'b00, 2'b00);
    tests++;
    if (obs_vec !== exp_vec || bus.state_out !== 3'd2 || bus.drop_count !== 16'd2) begin
      fails++; $display("FAIL rstmid_before obs=%h exp=%h", obs_vec, exp_vec);
    end
    advance();
    drive(0, 0, 0, 1, 1, 2'b00, 2'b00);
    tests++;
    if (obs_vec !== 27'd0) begin
      fails++; $display("FAIL rstmid_after obs=%h exp=0", obs_vec);
    end
    advance();
    drive(0, 1, 0, 0, 0, 2'b00, 2'b00); advance();
    drive(0, 0, 0, 1, 0, 2'b00, 2'b00);
    tests++;
    if ({bus.state_out, bus.wr_en, bus.overrun, bus.drop_count}
        !== {3'd1, 2'b01, 1'b0, 16'd0}) begin
      fails++; $display("FAIL rstmid_restart obs=%h exp=%h", obs_vec, exp_vec);
    end
    advance();
  endtask

  task automatic test_random();
    bit r, st, sp, v, rr;
    logic [1:0] sf, se;
    restart();
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 399) == 0);
      st = ($urandom_range(0, 11) == 0);
      sp = ($urandom_range(0, 49) == 0);
      v  = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) != 0);
      for (int b = 0; b < 2; b++) begin
        sf[b] = ($urandom_range(0, 7) == 0);
        se[b] = ($urandom_range(0, 7) == 0);
      end
      drive(r, st, sp, v, rr, sf, se);
      tests++;
      if (obs_vec !== exp_vec) begin
        fails++; $display("FAIL random cyc%0d obs=%h exp=%h", i, obs_vec, exp_vec);
      end
      advance();
    end
  endtask

  initial begin
    bus.start = 0; bus.stop = 0; bus.sample_valid = 0; bus.rd_ready = 0;
    bus.ff_full = 2'b00; bus.ff_empty = 2'b11;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_stream();
    test_overrun();
    test_stop();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pingpong_merge_ctrl.md
Name: pingpong_merge_ctrl

Overview:
- Single-clock sequencer for a two-bank ping-pong FIFO pair on the receiver sample path.
- Fills one bank with a fixed-length block of samples while the other bank drains to the downstream consumer, then swaps the banks.
- Drives per-bank write/read enables from FIFO status flags, detects overruns and counts dropped samples.
- Sits between the ADC sample-valid stream and the two bank FIFOs; the data path itself does not pass through this block.

Parameters:
- BLOCK_LEN, 16, samples per block (per bank fill). Must be >= 2 and <= FIFO depth.
- CNT_W, 16, width of the dropped-sample counter.

Ports:
- clock, input, 1, system clock; all logic on the rising edge.
- reset, input, 1, synchronous, active-high. Clears all state.
- start, input, 1, single-cycle pulse; arms the controller from IDLE.
- stop, input, 1, single-cycle pulse; finish the current block, drain it, return to IDLE.
- sample_valid, input, 1, an input sample is present this cycle.
- rd_ready, input, 1, downstream accepts a read this cycle.
- ff_full, input, 2, full flags; bit0 = bank0, bit1 = bank1.
- ff_empty, input, 2, empty flags; bit0 = bank0, bit1 = bank1.
- wr_en, output, 2, per-bank write enable; at most one bit high.
- rd_en, output, 2, per-bank read enable; at most one bit high.
- wr_bank, output, 1, bank currently being filled.
- rd_bank, output, 1, bank currently being drained.
- block_done, output, 1, one-cycle pulse when a bank's block has been fully read.
- overrun, output, 1, sticky error flag.
- drop_count, output, CNT_W, saturating count of dropped samples.
- state_out, output, 3, current state encoding.

Behaviour:

Reset:
- All outputs are 0 and state is IDLE.
- wr_cnt, rd_cnt and stop_pending are cleared.
- Reset does not flush the bank FIFOs; the bank FIFOs have their own reset.

Enables (combinational from registered state, zero latency):
- wr_en[wr_bank] = sample_valid & writing & ~ff_full[wr_bank]. "writing" is true in FILL and PINGPONG.
- rd_en[rd_bank] = rd_active & rd_ready & ~ff_empty[rd_bank]. rd_active is true in PINGPONG, WAIT_RD and DRAIN.

Counters:
- wr_cnt counts accepted writes, 0..BLOCK_LEN-1.
- wc (write complete) = an accepted write while wr_cnt == BLOCK_LEN-1; wr_cnt then wraps to 0.
- rd_cnt counts accepted reads.
- rc (read complete) = an accepted read while rd_cnt == BLOCK_LEN-1; rd_cnt wraps to 0 and block_done pulses in the next cycle.
- swap means: rd_bank <= wr_bank, wr_bank <= ~wr_bank.

Drops:
- Any sample_valid cycle in FILL, PINGPONG or WAIT_RD that is not written counts as a drop: drop_count += 1 (saturating at all-ones) and overrun <= 1.
- In FILL and PINGPONG this is a write blocked by ff_full[wr_bank].
- Samples arriving in IDLE or DRAIN are ignored and are not counted.

stop:
- stop latches stop_pending, honoured only at a block boundary.
- stop in IDLE is ignored.

start:
- start outside IDLE is ignored.
- start in IDLE clears overrun, drop_count, counters and stop_pending, sets wr_bank = 0, and goes to FILL.

States (state_out encoding):
- IDLE = 0: no enables asserted.
- FILL = 1: writing, no read active.
  - wc → swap; go to DRAIN if stop_pending (or stop this cycle), else PINGPONG.
- PINGPONG = 2: writing one bank, reading the other.
  - rc only → FILL.
  - wc only → WAIT_RD.
  - wc & rc in the same cycle → swap; stay in PINGPONG, or go to DRAIN if stop_pending.
- WAIT_RD = 3: write bank holds a full block; the other bank is still draining, so every sample is dropped.
  - rc → swap; go to PINGPONG, or DRAIN if stop_pending.
- DRAIN = 4: reading the last block, no writes.
  - rc → IDLE.
- Encodings 5–7 are unreachable and recover to IDLE.

Boundary rules:
- stop and wc in the same cycle: the stop counts as pending for that wc.
- ff_empty high mid-block: reads stall; rd_cnt holds.
- reset while in any state: the next cycle shows IDLE with all outputs 0.

Test Plan:
(All scenarios use BLOCK_LEN=4, CNT_W=16, with behavioural FIFO models of depth 8.)
1. Reset, start, sample_valid=1 for 4 cycles, rd_ready=0 → wr_en=01 for 4 cycles, then wr_bank=1, rd_bank=0, state_out=2, rd_en=00.
2. Continuous sample_valid and rd_ready=1 for 40 cycles → wr_en alternates 01/10 every 4 writes; block_done pulses every 4 cycles after the first block; drop_count=0; overrun=0.
3. sample_valid=1, rd_ready=0 for 11 cycles → state_out=3 after the 8th write, drop_count=3, overrun=1. Then raise rd_ready → after 4 reads, swap and state_out=2.
4. stop pulsed after 2 writes of a block → 2 more writes complete the block, state_out=4, wr_en stays 00; after the final 4 reads, block_done pulses and state_out=0.
5. Align the 4th write and the 4th read in the same cycle while in PINGPONG → state stays 2; wr_bank and rd_bank both toggle in one cycle; block_done pulses once.
6. Assert reset for one cycle mid-PINGPONG → next cycle all outputs are 0 and state_out=0. A following start works normally and drop_count restarts from 0.
